// File: rtl/adder_share_arb.sv
// adder_share_arb
//
// Round-robin arbiter that lets two requesters share one combinational adder.
// The winning operand pair is steered onto the shared adder. The returned sum,
// the requester index and the signed-overflow flag are captured in a
// one-entry result register. That register has a valid/ready handshake toward
// the consumer.
//
// Ports
//   clk_i                    rising-edge clock
//   rst_i                    synchronous active-low reset
//   req0_valid_i/_src1_i/_src2_i, req0_ready_o   requester 0 handshake + operands
//   req1_valid_i/_src1_i/_src2_i, req1_ready_o   requester 1 handshake + operands
//   add_src1_o, add_src2_o   operands driven to the shared adder
//   add_sum_i                sum returned combinationally by the shared adder
//   res_valid_o, res_ready_i result handshake toward the consumer
//   res_data_o, res_id_o, res_ovf_o   registered sum, requester index, overflow
//
// State table
//   state | meaning
//   EMPTY | result register holds nothing; any grant is accepted
//   FULL  | result register holds a result; accept only when it drains this cycle

module adder_share_arb #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_valid_i,
    input  logic [DATA_W-1:0] req0_src1_i,
    input  logic [DATA_W-1:0] req0_src2_i,
    output logic              req0_ready_o,
    input  logic              req1_valid_i,
    input  logic [DATA_W-1:0] req1_src1_i,
    input  logic [DATA_W-1:0] req1_src2_i,
    output logic              req1_ready_o,
    output logic [DATA_W-1:0] add_src1_o,
    output logic [DATA_W-1:0] add_src2_o,
    input  logic [DATA_W-1:0] add_sum_i,
    output logic              res_valid_o,
    output logic [DATA_W-1:0] res_data_o,
    output logic              res_id_o,
    output logic              res_ovf_o,
    input  logic              res_ready_i
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state;
    logic   last_grant;
    logic   grant_valid;
    logic   grant_id;
    logic   can_accept;
    logic   accept;
    logic   ovf_next;

    // Under contention the winner is the index that did not win last time.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant_valid = 1'b1;
            grant_id    = ~last_grant;
        end else if (req0_valid_i) begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
        end else if (req1_valid_i) begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
        end
    end

    assign can_accept   = (state == EMPTY) || res_ready_i;
    assign accept       = can_accept && grant_valid;
    assign req0_ready_o = accept && !grant_id;
    assign req1_ready_o = accept && grant_id;

    // Steering ignores can_accept so the operands stay visible during a stall.
    always_comb begin
        add_src1_o = '0;
        add_src2_o = '0;
        if (grant_valid) begin
            if (grant_id) begin
                add_src1_o = req1_src1_i;
                add_src2_o = req1_src2_i;
            end else begin
                add_src1_o = req0_src1_i;
                add_src2_o = req0_src2_i;
            end
        end
    end

    // Signed overflow: operands agree in sign but the sum does not.
    assign ovf_next = (add_src1_o[DATA_W-1] == add_src2_o[DATA_W-1]) &&
                      (add_sum_i[DATA_W-1] != add_src1_o[DATA_W-1]);

    assign res_valid_o = (state == FULL);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state      <= EMPTY;
            res_data_o <= '0;
            res_id_o   <= 1'b0;
            res_ovf_o  <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            // Covers the drain-and-refill case: the new result overwrites with no bubble.
            state      <= FULL;
            res_data_o <= add_sum_i;
            res_id_o   <= grant_id;
            res_ovf_o  <= ovf_next;
            last_grant <= grant_id;
        end else if ((state == FULL) && res_ready_i) begin
            state <= EMPTY;
        end
    end

endmodule

// File: tb/tb_adder_share_arb.sv
module tb_adder_share_arb;

    localparam int DATA_W = 32;

    logic              clk_i;
    logic              rst_i;
    logic              req0_valid_i;
    logic [DATA_W-1:0] req0_src1_i;
    logic [DATA_W-1:0] req0_src2_i;
    logic              req0_ready_o;
    logic              req1_valid_i;
    logic [DATA_W-1:0] req1_src1_i;
    logic [DATA_W-1:0] req1_src2_i;
    logic              req1_ready_o;
    logic [DATA_W-1:0] add_src1_o;
    logic [DATA_W-1:0] add_src2_o;
    logic [DATA_W-1:0] add_sum_i;
    logic              res_valid_o;
    logic [DATA_W-1:0] res_data_o;
    logic              res_id_o;
    logic              res_ovf_o;
    logic              res_ready_i;

    typedef struct packed {
        logic              id;
        logic [DATA_W-1:0] data;
        logic              ovf;
    } res_t;

    res_t q[$];
    int   n_vec;
    int   n_err;

    adder_share_arb #(.DATA_W(DATA_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req0_valid_i (req0_valid_i),
        .req0_src1_i  (req0_src1_i),
        .req0_src2_i  (req0_src2_i),
        .req0_ready_o (req0_ready_o),
        .req1_valid_i (req1_valid_i),
        .req1_src1_i  (req1_src1_i),
        .req1_src2_i  (req1_src2_i),
        .req1_ready_o (req1_ready_o),
        .add_src1_o   (add_src1_o),
        .add_src2_o   (add_src2_o),
        .add_sum_i    (add_sum_i),
        .res_valid_o  (res_valid_o),
        .res_data_o   (res_data_o),
        .res_id_o     (res_id_o),
        .res_ovf_o    (res_ovf_o),
        .res_ready_i  (res_ready_i)
    );

    // The shared adder lives outside the arbiter.
    assign add_sum_i = add_src1_o + add_src2_o;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic res_t model(input logic id, input logic [DATA_W-1:0] a,
                                   input logic [DATA_W-1:0] b);
        res_t   r;
        longint sa;
        sa     = longint'($signed(a)) + longint'($signed(b));
        r.id   = id;
        r.data = a + b;
        r.ovf  = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, check after settling, and
    // let the rising edge commit. Expected readies are given explicitly.
    task automatic step(input logic v0, input logic [DATA_W-1:0] a0, input logic [DATA_W-1:0] b0,
                        input logic v1, input logic [DATA_W-1:0] a1, input logic [DATA_W-1:0] b1,
                        input logic rr, input logic e0, input logic e1);
        @(negedge clk_i);
        req0_valid_i = v0; req0_src1_i = a0; req0_src2_i = b0;
        req1_valid_i = v1; req1_src1_i = a1; req1_src2_i = b1;
        res_ready_i  = rr;
        #1;
        chk("res_valid", {31'b0, res_valid_o}, {31'b0, q.size() != 0});
        if (q.size() != 0) begin
            chk("res_data", res_data_o, q[0].data);
            chk("res_id", {31'b0, res_id_o}, {31'b0, q[0].id});
            chk("res_ovf", {31'b0, res_ovf_o}, {31'b0, q[0].ovf});
            if (rr) void'(q.pop_front());
        end
        chk("req0_ready", {31'b0, req0_ready_o}, {31'b0, e0});
        chk("req1_ready", {31'b0, req1_ready_o}, {31'b0, e1});
        if (e0) begin
            chk("add_src1", add_src1_o, a0);
            q.push_back(model(1'b0, a0, b0));
        end
        if (e1) begin
            chk("add_src1", add_src1_o, a1);
            q.push_back(model(1'b1, a1, b1));
        end
    endtask

    task automatic check_reset_values();
        chk("rst_valid", {31'b0, res_valid_o}, 32'd0);
        chk("rst_data", res_data_o, 32'd0);
        chk("rst_id", {31'b0, res_id_o}, 32'd0);
        chk("rst_ovf", {31'b0, res_ovf_o}, 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_i = 1'b0;
        req0_valid_i = 1'b0; req0_src1_i = '0; req0_src2_i = '0;
        req1_valid_i = 1'b0; req1_src1_i = '0; req1_src2_i = '0;
        res_ready_i  = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check_reset_values();

        // Single request 5+7
        step(1, 5, 7, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Signed overflow on requester 1 (last_grant becomes 1)
        step(0, 0, 0, 1, 32'h7FFF_FFFF, 32'd1, 1, 0, 1);

        // Continuous contention: 0,1,0,1 with no bubble
        step(1, 10, 20, 1, 100, 200, 1, 1, 0);
        step(1, 11, 21, 1, 101, 201, 1, 0, 1);
        step(1, 12, 22, 1, 102, 202, 1, 1, 0);
        step(1, 13, 23, 1, 103, 203, 1, 0, 1);

        // Unsigned wrap without signed overflow
        step(1, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Backpressure: fill via req1, stall 3 cycles, then drain+accept
        step(0, 0, 0, 1, 3, 4, 1, 0, 1);
        step(1, 40, 41, 1, 50, 51, 0, 0, 0);
        step(1, 40, 41, 1, 50, 51, 0, 0, 0);
        step(1, 40, 41, 1, 50, 51, 0, 0, 0);
        step(1, 40, 41, 1, 50, 51, 1, 1, 0);
        step(0, 0, 0, 1, 50, 51, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Reset while FULL and stalled
        step(1, 1, 2, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        q.delete();
        #1;
        check_reset_values();
        step(1, 7, 8, 1, 9, 10, 1, 1, 0);
        step(1, 7, 8, 1, 9, 10, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Round-robin arbiter that time-shares one combinational 32-bit Adder instance between two requesters, e.g. the PC-increment path and the branch-target path in the multi-cycle datapath variant.
- Each requester presents an operand pair with a valid/ready handshake.
- The arbiter steers the winning pair onto the shared Adder and captures the sum with its requester tag in a one-entry output register.
- The output register has its own valid/ready handshake toward the consumer.

Parameters:
- DATA_W, 32, operand/sum width; must match the width of the shared Adder.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-low reset.
- req0_valid_i  input  1  requester 0 has an operand pair.
- req0_src1_i  input  DATA_W  requester 0 operand 1.
- req0_src2_i  input  DATA_W  requester 0 operand 2.
- req0_ready_o  output  1  requester 0 pair accepted this cycle.
- req1_valid_i  input  1  requester 1 has an operand pair.
- req1_src1_i  input  DATA_W  requester 1 operand 1.
- req1_src2_i  input  DATA_W  requester 1 operand 2.
- req1_ready_o  output  1  requester 1 pair accepted this cycle.
- add_src1_o  output  DATA_W  operand 1 to the shared Adder.
- add_src2_o  output  DATA_W  operand 2 to the shared Adder.
- add_sum_i  input  DATA_W  sum returned by the shared Adder (combinational).
- res_valid_o  output  1  result register holds a result.
- res_data_o  output  DATA_W  registered sum.
- res_id_o  output  1  requester index that produced res_data_o.
- res_ovf_o  output  1  two's-complement signed overflow of that addition.
- res_ready_i  input  1  consumer takes the result this cycle.

Behaviour:
- Reset (rst_i low at a clock edge) forces the following, regardless of any in-flight handshake:
  - res_valid_o=0, res_data_o=0, res_id_o=0, res_ovf_o=0.
  - last_grant=1, so requester 0 wins the first contention.
  - The pending result is discarded.
- Output register state machine:
  - EMPTY (res_valid_o=0) and FULL (res_valid_o=1).
  - can_accept = EMPTY, or (FULL and res_ready_i).
- Grant selection is combinational:
  - Only reqN_valid_i high -> grant N.
  - Both high -> grant the index not equal to last_grant.
  - Neither high -> no grant.
- Ready outputs:
  - reqN_ready_o = can_accept and (grant == N).
  - At most one ready is high per cycle.
  - Ready never asserts without the matching valid.
- Operand steering:
  - add_src1_o/add_src2_o carry the granted requester's operands.
  - With no grant, both are driven to 0.
  - Steering does not depend on can_accept, so operands are visible even while stalled.
- Accept (reqN_valid_i and reqN_ready_o), at the next edge:
  - res_data_o <= add_sum_i, res_id_o <= N, res_valid_o <= 1.
  - last_grant <= N.
  - res_ovf_o <= (src1[MSB]==src2[MSB]) and (sum[MSB]!=src1[MSB]).
- Latency:
  - Result is visible one cycle after acceptance.
  - Throughput is one accept per cycle when res_ready_i is held high.
- Drain without accept (FULL, res_ready_i=1, no grant):
  - res_valid_o <= 0 next edge; data/id/ovf hold their last values.
- Simultaneous drain and accept:
  - The new result replaces the old in the same edge; res_valid_o stays 1 with no bubble.
- Stall (FULL, res_ready_i=0):
  - Both ready outputs are 0; res_* holds stable.
  - last_grant is unchanged, so the pending winner is preserved.
- Arithmetic:
  - Sum is modulo 2^DATA_W; carry-out is dropped.
  - Overflow is reported only through res_ovf_o.
- Fairness:
  - Under continuous contention, grants alternate 0,1,0,1.
  - No requester waits more than one accepted transaction.
- Requesters must hold valid and operands stable until ready; the block does not check this.

Test Plan:
- Reset, then req0 only with 5+7, res_ready_i=1:
  - req0_ready_o=1 in cycle 0.
  - Next cycle res_valid_o=1, res_data_o=12, res_id_o=0, res_ovf_o=0.
- Both requests valid for 4 cycles, res_ready_i=1:
  - Accept order 0,1,0,1.
  - res_valid_o stays high continuously after the first accept.
  - res_id_o sequence 0,1,0,1.
- req1 0x7FFFFFFF+1 -> res_data_o=0x80000000, res_ovf_o=1.
- req0 0xFFFFFFFF+1 -> res_data_o=0, res_ovf_o=0 (wrap, no signed overflow).
- Backpressure:
  - Fill the register, hold res_ready_i=0 for 3 cycles with both requests valid.
  - Both ready outputs stay 0 and res_* stays unchanged.
  - Raise res_ready_i: the correct round-robin winner is accepted in the same cycle as the drain.
- Reset mid-operation:
  - FULL with res_ready_i=0, assert rst_i low for 1 cycle.
  - res_valid_o=0 afterwards.
  - Next contention grants requester 0 first.
